// File: rtl/lowp_interp.sv
// rtl/lowp_interp.sv - interpolating reconstruction filter
// Zero-order hold followed by a LEN-tap running average; linear interpolation between inputs.
module lowp_interp #(
   parameter  int LOG2_L = 3,
   localparam int LEN    = 2 ** LOG2_L,
   parameter  int AW     = 28 + LOG2_L
) (
   input  logic                 clock_in,
   input  logic                 reset,
   input  logic                 enable,
   input  logic signed [27:0]   in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic signed [27:0]   out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [AW-1:0] out_acc,
   output logic                 underrun
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]              state;
   logic [LOG2_L-1:0]       phase;
   logic signed [AW-1:0]    acc;
   logic signed [27:0]      x_prev;
   logic signed [27:0]      x_cur;
   logic signed [28:0]      delta;

   logic                    adv;
   logic                    gen;
   logic                    burst_end;
   logic                    accept;
   logic signed [27:0]      x_prev_eff;
   logic signed [AW-1:0]    sum;

   assign adv       = enable && (!out_valid || out_ready);
   assign gen       = (state == RUN) && adv;
   assign burst_end = gen && (phase == LOG2_L'(LEN - 1));
   assign in_ready  = enable && ((state == IDLE) || burst_end);
   assign accept    = in_valid && in_ready;
   // A sample accepted on the last phase must see x_prev already advanced to x_cur.
   assign x_prev_eff = burst_end ? x_cur : x_prev;
   assign sum        = acc + AW'(delta);

   always_ff @(posedge clock_in) begin
      if (reset) begin
         state     <= IDLE;
         phase     <= '0;
         acc       <= '0;
         x_prev    <= '0;
         x_cur     <= '0;
         delta     <= '0;
         out_data  <= '0;
         out_acc   <= '0;
         out_valid <= 1'b0;
         underrun  <= 1'b0;
      end else if (enable) begin
         if (gen) begin
            acc       <= sum;
            out_acc   <= sum;
            out_data  <= 28'(sum >>> LOG2_L);
            out_valid <= 1'b1;
            phase     <= phase + 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (burst_end)
            x_prev <= x_cur;

         if (accept) begin
            x_cur <= in_data;
            delta <= 29'(in_data) - 29'(x_prev_eff);
            phase <= '0;
            state <= RUN;
         end else if (burst_end) begin
            state <= IDLE;
         end

         underrun <= burst_end && !accept;
      end
   end

endmodule

// File: tb/tb_lowp_interp.sv
// tb/tb_lowp_interp.sv - directed bench for lowp_interp
// Outputs are collected at negedge on every accepted handshake and compared with hand values.
module tb_lowp_interp;

   logic               clock_in;
   logic               reset;
   logic               enable;
   logic signed [27:0] in_data;
   logic               in_valid;
   logic               in_ready;
   logic signed [27:0] out_data;
   logic               out_valid;
   logic               out_ready;
   logic signed [30:0] out_acc;
   logic               underrun;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int qd[$];
   int qa[$];
   int qc[$];
   int ucnt = 0;
   int rdy_hi = 0;
   int stall_err = 0;
   int base;
   int u0, r0, s0, mono;
   logic busy = 1'b0;
   logic rmode = 1'b0;
   int pc = 0;
   logic pv = 1'b0;
   logic pr = 1'b0;
   logic signed [27:0] pd = '0;

   lowp_interp dut (
      .clock_in  (clock_in),
      .reset     (reset),
      .enable    (enable),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .underrun  (underrun)
   );

   initial clock_in = 1'b0;
   always #5 clock_in = ~clock_in;

   always @(posedge clock_in) cyc <= cyc + 1;

   // Downstream ready: always high, or the repeating 1,0,0 pattern.
   always @(posedge clock_in) begin
      #1;
      if (rmode) begin
         out_ready = (pc == 0);
         pc = (pc == 2) ? 0 : pc + 1;
      end else begin
         out_ready = 1'b1;
         pc = 0;
      end
   end

   always @(negedge clock_in) begin
      if (!reset) begin
         if (enable && out_valid && out_ready) begin
            qd.push_back(int'(out_data));
            qa.push_back(int'(out_acc));
            qc.push_back(cyc);
         end
         if (underrun) ucnt++;
         if (busy && in_ready) rdy_hi++;
         if (pv && !pr && out_valid && out_data != pd) stall_err++;
      end
      pv = out_valid && !reset;
      pr = out_ready;
      pd = out_data;
   end

   task automatic chk(input string tag, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock_in);
      #1 reset = 1'b0;
   endtask

   task automatic send(input int d);
      in_data  = 28'(d);
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock_in);
         if (in_ready) begin
            @(posedge clock_in);
            #1 in_valid = 1'b0;
            return;
         end
      end
      chk("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_n(input int n);
      for (int i = 0; i < 300 && qd.size() < base + n; i++) @(posedge clock_in);
      if (qd.size() < base + n) chk("out_timeout", qd.size() - base, n);
   endtask

   task automatic check_seq(input string tag, input int off, input int start, input int step, input int n);
      for (int i = 0; i < n; i++) begin
         if (base + off + i < qd.size())
            chk(tag, qd[base + off + i], start + step * i);
         else
            chk(tag, 0, 1);
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

      // 1: reset state, ramp to 800, latency, underrun
      do_reset();
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_acc", out_acc, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_in_ready", in_ready, 1);
      u0 = ucnt; base = qd.size();
      send(800);
      @(negedge clock_in) chk("lat_k", out_valid, 0);
      @(negedge clock_in) chk("lat_k1", out_valid, 1);
      wait_n(8);
      check_seq("t1_ramp", 0, 100, 100, 8);
      repeat (3) @(posedge clock_in);
      #1;
      chk("t1_underrun", ucnt - u0, 1);
      chk("t1_idle_ready", in_ready, 1);
      chk("t1_idle_valid", out_valid, 0);

      // 2: back-to-back bursts, no gap
      u0 = ucnt; base = qd.size();
      send(800);
      send(0);
      wait_n(16);
      check_seq("t2_hold", 0, 800, 0, 8);
      check_seq("t2_down", 8, 700, -100, 8);
      chk("t2_gap", qc[base + 15] - qc[base], 15);
      chk("t2_acc", qa[base + 15], 0);
      repeat (3) @(posedge clock_in);
      chk("t2_underrun", ucnt - u0, 1);

      // 3: floor truncation
      do_reset(); base = qd.size();
      send(-8);
      wait_n(8);
      check_seq("t3_neg", 0, -1, -1, 8);
      do_reset(); base = qd.size();
      send(7);
      wait_n(8);
      check_seq("t3_floor", 0, 0, 1, 8);

      // 4: backpressure with ready pattern 1,0,0
      do_reset(); base = qd.size();
      rmode = 1'b1;
      r0 = rdy_hi; s0 = stall_err;
      send(800);
      busy = 1'b1;
      send(800);
      busy = 1'b0;
      wait_n(16);
      check_seq("t4_ramp", 0, 100, 100, 8);
      check_seq("t4_hold", 8, 800, 0, 8);
      chk("t4_ready_once", rdy_hi - r0, 1);
      chk("t4_stall_stable", stall_err - s0, 0);
      rmode = 1'b0;
      repeat (4) @(posedge clock_in);

      // 5: full-scale extremes
      do_reset(); base = qd.size();
      send(134217727);
      send(-134217728);
      wait_n(16);
      chk("t5_mid_up", qd[base + 3], 67108863);
      chk("t5_top", qd[base + 7], 134217727);
      chk("t5_mid_down", qd[base + 11], -1);
      chk("t5_bottom", qd[base + 15], -134217728);
      mono = 0;
      for (int i = 8; i < 16; i++)
         if (qd[base + i] >= qd[base + i - 1]) mono++;
      chk("t5_monotone", mono, 0);

      // 6a: enable low mid-burst
      do_reset(); base = qd.size();
      send(800);
      wait_n(3);
      #1 enable = 1'b0;
      repeat (5) @(posedge clock_in);
      @(negedge clock_in);
      chk("t6_frozen_cnt", qd.size() - base, 3);
      chk("t6_frozen_valid", out_valid, 1);
      chk("t6_frozen_data", out_data, 400);
      chk("t6_frozen_ready", in_ready, 0);
      @(posedge clock_in);
      #1 enable = 1'b1;
      wait_n(8);
      check_seq("t6_resume", 0, 100, 100, 8);
      repeat (3) @(posedge clock_in);

      // 6b: reset mid-burst
      do_reset(); base = qd.size();
      send(800);
      wait_n(4);
      #1 reset = 1'b1;
      @(posedge clock_in);
      #1 reset = 1'b0;
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_acc", out_acc, 0);
      chk("t6_rst_data", out_data, 0);
      chk("t6_rst_ready", in_ready, 1);
      base = qd.size();
      send(80);
      wait_n(8);
      check_seq("t6_after_rst", 0, 10, 10, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lowp_interp.md
Name: lowp_interp

Overview:
- Interpolating reconstruction filter: the upsampling counterpart of the team's boxcar decimating lowpass.
- Accepts 28-bit signed samples at a low rate and emits LEN output samples per input.
- The output is a zero-order hold followed by a LEN-tap recursive moving average, which gives linear interpolation between consecutive inputs.
- Sits between a decimated processing path and the full-rate output path; valid/ready on both sides.

Parameters:
- LOG2_L, 3: log2 of the interpolation factor.
- LEN, 2**LOG2_L: interpolation factor; outputs per accepted input. Derived, not overridable.
- AW, 28+LOG2_L: accumulator width.

Ports:
- clock_in  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  high = operate; low = freeze all state and outputs
- in_data  input  28  signed input sample
- in_valid  input  1  upstream sample present
- in_ready  output  1  block can accept a sample this cycle
- out_data  output  28  signed interpolated sample
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_acc  output  AW  signed full-precision accumulator behind out_data
- underrun  output  1  one-cycle pulse: burst finished with no next sample accepted

Behaviour:
- **Reset (reset=1 at posedge clock_in):**
  - Clears state->IDLE, phase=0, acc=0, x_prev=0, x_cur=0, delta=0.
  - Clears out_data=0, out_acc=0, out_valid=0, underrun=0.
  - Reset overrides enable. Reset mid-burst discards the partial burst.
- **Registers:** x_prev/x_cur 28b signed; delta 29b signed; acc AW signed; phase LOG2_L bits.
- **Invariant:** acc = LEN*x_prev + (phase+1)*delta after each generated output.
- **States:** IDLE, RUN.
- **adv** = enable && (!out_valid || out_ready): the output slot is free, so a new output may be generated.
- **in_ready** (combinational) = enable && (state==IDLE || (state==RUN && phase==LEN-1 && adv)).
- **Accept:** when in_valid && in_ready,
  - x_cur <= in_data.
  - delta <= in_data - x_prev, computed using x_prev after any same-cycle update.
  - phase <= 0; state <= RUN.
- **RUN, each cycle with adv:**
  - acc <= acc + delta.
  - out_acc <= acc + delta.
  - out_data <= (acc + delta) >>> LOG2_L: arithmetic shift, truncation toward -inf.
  - out_valid <= 1; phase <= phase+1.
- **Burst end:** when phase==LEN-1 and adv,
  - x_prev <= x_cur.
  - If a sample is accepted the same cycle: stay RUN with new x_cur and delta (in_data - x_cur), phase 0. This gives back-to-back bursts with no gap.
  - Otherwise: state <= IDLE and underrun pulses high for the next cycle.
- **Output handshake:**
  - out_valid drops only when out_ready && !adv-generation. In IDLE, out_valid <= 0 once out_ready is seen.
  - out_data holds stable while out_valid && !out_ready.
- **Latency:** sample accepted at edge k -> first output valid after edge k+1 (when out_ready is held high). Then one output per cycle, LEN outputs per input. Sustained throughput = 1 output/cycle.
- **First sample after reset:** interpolates from x_prev=0.
- **After underrun:** the next sample interpolates from the last x_cur. acc remains exactly LEN*x_prev in IDLE, so there is no glitch.
- **enable=0:**
  - No accept (in_ready=0), no generation, all registers hold.
  - out_valid is held; a downstream handshake during enable=0 does not clear it.
- **Overflow:** none possible. |delta| < 2^28 and acc stays within [LEN*min, LEN*max] of two consecutive inputs.
- **Boundary cases:** in_data = -2^27 following x_prev = 2^27-1 gives delta = -(2^28-1), which is handled in 29 bits.

Test Plan:
1. LOG2_L=3; after reset, input 800 with out_ready=1 -> outputs 100,200,300,400,500,600,700,800 on 8 consecutive cycles; then underrun pulse; in_ready=1 in IDLE.
2. Continue with input 0 offered at burst end -> no gap: outputs 700,600,...,100,0; out_acc final 0.
3. From x_prev=0, input -8 -> outputs -1..-8. From x_prev=0, input 7 -> outputs 0,1,2,3,4,5,6,7 (floor truncation).
4. Burst of 800 with out_ready toggling 1,0,0,1,... -> same 8 values in order, none dropped or duplicated, out_data stable while stalled; in_ready asserts only on the last-phase advance.
5. Extremes: 2^27-1 then -2^27 -> first burst ends exactly 2^27-1; second burst descends monotonically to -2^27 with no wrap.
6. Control events:
   - enable=0 mid-burst for 5 cycles -> outputs freeze, then resume at the correct phase.
   - reset asserted at phase 4 -> out_valid=0 next cycle, acc=0, and the next input 80 yields 10,20,...,80.
